// File: rtl/m68k_bus_sync_pkg.sv
// Shared constants for the 68000 bus synchroniser: acknowledge channel
// indices, default delays for a 120 MHz SYSCLK and sync-chain reset levels.
package m68k_bus_pkg;

  // Acknowledge channel indices into ACK_n / ACK_LATCH.
  localparam int ACK_DTACK = 0;
  localparam int ACK_VPA   = 1;
  localparam int ACK_BERR  = 2;

  // Defaults for a 120 MHz SYSCLK (read delay of 15 cycles is 125 ns).
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_READ_DELAY  = 15;
  localparam int DEF_WRITE_DELAY = 2;

  // Reset levels of the synchroniser chains: MCCLK idles low, the
  // active-low acknowledges idle deasserted (high).
  localparam logic MC_SYNC_RST  = 1'b0;
  localparam logic ACK_SYNC_RST = 1'b1;

endpackage

// File: rtl/m68k_bus_sync_if.sv
// Bus-side signal bundle of the synchroniser. The slave modport is the
// synchroniser itself; the master modport is the bus FSM / driver side.
// Handshake: there is no valid/ready pair; ACK_n is a level that stays low
// for as long as the peripheral acknowledges, and ACK_LATCH follows it with
// a fixed delay, staying high until ACK_n is released.
interface m68k_bus_sync_if #(
  parameter int N_ACK    = 3,
  parameter int PERIOD_W = 8
);
  logic                MCCLK;
  logic [N_ACK-1:0]    ACK_n;
  logic                RW;
  logic                MCCLK_SYNC;
  logic                MCCLK_RISING;
  logic                MCCLK_FALLING;
  logic [PERIOD_W-1:0] MCCLK_PHASE;
  logic [PERIOD_W-1:0] PERIOD;
  logic                PERIOD_VALID;
  logic [N_ACK-1:0]    ACK_LATCH;
  logic                ANY_LATCH;

  modport slave (
    input  MCCLK, ACK_n, RW,
    output MCCLK_SYNC, MCCLK_RISING, MCCLK_FALLING, MCCLK_PHASE,
           PERIOD, PERIOD_VALID, ACK_LATCH, ANY_LATCH
  );

  modport master (
    output MCCLK, ACK_n, RW,
    input  MCCLK_SYNC, MCCLK_RISING, MCCLK_FALLING, MCCLK_PHASE,
           PERIOD, PERIOD_VALID, ACK_LATCH, ANY_LATCH
  );
endinterface

// File: rtl/m68k_bus_sync_ack_delay_channel.sv
// One acknowledge channel: synchronises an active-low ACK input and raises
// a latch once it has been seen low for D+1 consecutive synced samples,
// where D is chosen from RW on the first low sample and then frozen.
module ack_delay_channel
  import m68k_bus_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = 8,
  parameter int READ_DELAY  = DEF_READ_DELAY,
  parameter int WRITE_DELAY = DEF_WRITE_DELAY
) (
  input  logic SYSCLK,
  input  logic nRESET,
  input  logic ACK_n,
  input  logic RW,
  output logic latch,
  output logic latch_nxt
);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("ack_delay_channel: SYNC_STAGES must be at least 2");
  end
  if (READ_DELAY > (2 ** CNT_W) - 1 || WRITE_DELAY > (2 ** CNT_W) - 1) begin : g_bad_delay
    $error("ack_delay_channel: delay does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] RD_C = CNT_W'(READ_DELAY);
  localparam logic [CNT_W-1:0] WR_C = CNT_W'(WRITE_DELAY);

  logic [SYNC_STAGES-1:0] chain;
  logic                   a_s;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [CNT_W-1:0]       d_hold, d_nxt, d_cur;
  logic                   first;

  assign a_s = chain[SYNC_STAGES-1];

  // Next-state of counter, frozen delay and latch; the delay is taken from
  // RW only on the first low sample so later RW changes are ignored.
  always_comb begin
    first     = (cnt == '0) && !latch;
    d_cur     = first ? (RW ? RD_C : WR_C) : d_hold;
    cnt_nxt   = cnt;
    d_nxt     = d_hold;
    latch_nxt = latch;
    if (!nRESET || a_s) begin
      cnt_nxt   = '0;
      d_nxt     = '0;
      latch_nxt = 1'b0;
    end else begin
      d_nxt = d_cur;
      if (cnt < d_cur) cnt_nxt = cnt + 1'b1;
      else             latch_nxt = 1'b1;
    end
  end

  // Synchroniser chain and channel state, all on the SYSCLK falling edge.
  always_ff @(negedge SYSCLK) begin
    if (!nRESET) begin
      chain  <= {SYNC_STAGES{ACK_SYNC_RST}};
      cnt    <= '0;
      d_hold <= '0;
      latch  <= 1'b0;
    end else begin
      chain  <= {chain[SYNC_STAGES-2:0], ACK_n};
      cnt    <= cnt_nxt;
      d_hold <= d_nxt;
      latch  <= latch_nxt;
    end
  end

endmodule

// File: rtl/m68k_bus_sync.sv
// 68000 bus synchroniser: MCCLK edge strobes, phase counter and period
// measurement in the SYSCLK domain, plus N delayed acknowledge latches.
module m68k_bus_sync
  import m68k_bus_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int N_ACK       = 3,
  parameter int CNT_W       = 8,
  parameter int READ_DELAY  = DEF_READ_DELAY,
  parameter int WRITE_DELAY = DEF_WRITE_DELAY,
  parameter int PERIOD_W    = 8
) (
  input logic             SYSCLK,
  input logic             nRESET,
  m68k_bus_sync_if.slave  bus
);

  localparam int                  WARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0]   WARM_LOAD = WARM_W'(SYNC_STAGES + 1);
  localparam logic [PERIOD_W-1:0] PH_MAX    = '1;

  logic [SYNC_STAGES-1:0] mc_chain;
  logic                   mc_s, mc_d;
  logic [WARM_W-1:0]      warm;
  logic                   rise_nxt, fall_nxt;
  logic                   rising, falling;
  logic [PERIOD_W-1:0]    phase_cnt, phase_inc, period;
  logic                   period_valid, seen_rise;
  logic [N_ACK-1:0]       ack_latch, latch_nxt;
  logic                   any_latch;

  assign mc_s      = mc_chain[SYNC_STAGES-1];
  // The warm-up count hides the edge the chain would show while it fills.
  assign rise_nxt  = mc_s & ~mc_d & (warm == '0);
  assign fall_nxt  = ~mc_s & mc_d & (warm == '0);
  assign phase_inc = (phase_cnt == PH_MAX) ? PH_MAX : phase_cnt + 1'b1;

  // MCCLK sync, edge strobes, phase counter and period measurement.
  always_ff @(negedge SYSCLK) begin
    if (!nRESET) begin
      mc_chain     <= {SYNC_STAGES{MC_SYNC_RST}};
      mc_d         <= MC_SYNC_RST;
      warm         <= WARM_LOAD;
      rising       <= 1'b0;
      falling      <= 1'b0;
      phase_cnt    <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      seen_rise    <= 1'b0;
    end else begin
      mc_chain <= {mc_chain[SYNC_STAGES-2:0], bus.MCCLK};
      mc_d     <= mc_s;
      if (warm != '0) warm <= warm - 1'b1;
      rising   <= rise_nxt;
      falling  <= fall_nxt;
      if (rise_nxt) begin
        // The first rise only ends a partial period; the second is a full one.
        period    <= phase_inc;
        phase_cnt <= '0;
        seen_rise <= 1'b1;
        if (seen_rise) period_valid <= 1'b1;
      end else begin
        phase_cnt <= phase_inc;
        if (phase_inc == PH_MAX) begin
          // MCCLK considered stopped: the period must be re-measured.
          period_valid <= 1'b0;
          seen_rise    <= 1'b0;
        end
      end
    end
  end

  for (genvar i = 0; i < N_ACK; i++) begin : g_ch
    ack_delay_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .READ_DELAY  (READ_DELAY),
      .WRITE_DELAY (WRITE_DELAY)
    ) u_ch (
      .SYSCLK    (SYSCLK),
      .nRESET    (nRESET),
      .ACK_n     (bus.ACK_n[i]),
      .RW        (bus.RW),
      .latch     (ack_latch[i]),
      .latch_nxt (latch_nxt[i])
    );
  end

  // Registered OR of the channel next-states, aligned with ACK_LATCH.
  always_ff @(negedge SYSCLK) begin
    if (!nRESET) any_latch <= 1'b0;
    else         any_latch <= |latch_nxt;
  end

  assign bus.MCCLK_SYNC    = mc_s;
  assign bus.MCCLK_RISING  = rising;
  assign bus.MCCLK_FALLING = falling;
  assign bus.MCCLK_PHASE   = phase_cnt;
  assign bus.PERIOD        = period;
  assign bus.PERIOD_VALID  = period_valid;
  assign bus.ACK_LATCH     = ack_latch;
  assign bus.ANY_LATCH     = any_latch;

endmodule

// File: doc/m68k_bus_sync.md
Name: m68k_bus_sync

Overview:
- Successor to the single-DTACK clock synchroniser.
- Runs in the SYSCLK domain and produces single-cycle MCCLK edge strobes, plus a live MCCLK phase counter and a measured MCCLK period.
- Provides N independently delayed bus-acknowledge latches (DTACK, VPA, BERR…), with separate read and write delays selected per access.
- Feeds the PiStorm16 bus state machine, which uses these outputs to place its data-sample and strobe timing.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each async input (MCCLK and each ACK_n bit); minimum 2.
- N_ACK, 3, number of active-low acknowledge inputs/channels.
- CNT_W, 8, width of each channel delay counter.
- READ_DELAY, 15, SYSCLK cycles from synced assertion to latch for reads (120 MHz → 125 ns).
- WRITE_DELAY, 2, same as READ_DELAY, but for writes.
- PERIOD_W, 8, width of the phase counter and the PERIOD output.

Ports:
- SYSCLK, in, 1, sole clock; all flops update on the falling edge of SYSCLK.
- nRESET, in, 1, synchronous active-low reset, sampled on the SYSCLK falling edge.
- MCCLK, in, 1, async 68000 bus clock.
- ACK_n, in, N_ACK, async active-low acknowledges; bit 0 is DTACK.
- RW, in, 1, access direction from the bus FSM; 1 = read, 0 = write.
- MCCLK_SYNC, out, 1, synchronised MCCLK level.
- MCCLK_RISING, out, 1, one-cycle strobe on a synced rising edge.
- MCCLK_FALLING, out, 1, one-cycle strobe on a synced falling edge.
- MCCLK_PHASE, out, PERIOD_W, SYSCLK cycles since the last synced rising edge.
- PERIOD, out, PERIOD_W, length of the last full MCCLK period in SYSCLK cycles.
- PERIOD_VALID, out, 1, PERIOD is trustworthy.
- ACK_LATCH, out, N_ACK, per-channel delayed acknowledge, active high.
- ANY_LATCH, out, 1, OR of ACK_LATCH.

Behaviour:
- Reset (nRESET=0 at the falling edge):
  - All outputs go to 0.
  - The MCCLK chain loads 0; the ACK chains load 1 (deasserted).
  - Channel counters are cleared.
  - A warm-up counter is loaded with SYNC_STAGES+1.
- Reset mid-operation aborts all counts. No strobe or latch is emitted in the cycle where reset is asserted.
- Edge detect:
  - mc_s is the last chain stage; mc_d is mc_s delayed one cycle.
  - RISING = mc_s & ~mc_d; FALLING = ~mc_s & mc_d; each is registered, so it is a 1-cycle pulse.
  - Latency from an MCCLK transition to the strobe is SYNC_STAGES+1 falling edges.
  - Strobes are suppressed while the warm-up count is nonzero, so no spurious edge appears after reset.
- Phase and period:
  - phase_cnt increments every cycle and saturates at 2^PERIOD_W−1.
  - On a RISING strobe cycle: PERIOD <= phase_cnt+1 and phase_cnt <= 0.
  - PERIOD_VALID goes to 1 on the second rising strobe after reset.
  - PERIOD_VALID goes to 0 when phase_cnt saturates (MCCLK stopped). It recovers on the next two rising strobes.
  - MCCLK_PHASE = phase_cnt.
- Per channel i (sub-module), with a_s = synced ACK_n[i]:
  - a_s = 1 (deasserted): cnt <= 0, latch <= 0, mode cleared.
  - First low cycle (cnt=0, latch=0): capture the delay D = RW ? READ_DELAY : WRITE_DELAY. D stays frozen until a_s returns high; a later RW change has no effect.
  - a_s = 0 and cnt < D: cnt <= cnt+1.
  - a_s = 0 and cnt = D: latch <= 1, held until a_s = 1.
  - ACK_LATCH[i] rises after D+1 consecutive low synced samples. D = 0 means one sample.
  - Total latency from the async input is SYNC_STAGES+D+1 cycles.
  - Deassertion clears the latch SYNC_STAGES+1 cycles after the async input rises.
- A one-cycle high glitch on a_s during counting restarts the count from 0.
- Channels are fully independent. Simultaneous assertion gives identical timing per channel.
- ANY_LATCH is the registered OR of the ACK_LATCH next-state, so it has the same cycle as ACK_LATCH.
- Width rule: READ_DELAY and WRITE_DELAY must be ≤ 2^CNT_W−1. This is checked by an elaboration-time assertion.

Decomposition:
- Package m68k_bus_pkg:
  - Channel index constants ACK_DTACK=0, ACK_VPA=1, ACK_BERR=2.
  - Default delays for 120 MHz.
  - A shared sync-chain reset-value constant.
- Sub-module ack_delay_channel, instanced N_ACK times via generate:
  - Parameters: SYNC_STAGES, CNT_W, READ_DELAY, WRITE_DELAY.
  - Ports: SYSCLK, nRESET, ACK_n bit, RW, latch out.

Test Plan:
- Reset, then MCCLK at 7.09 MHz (≈17 SYSCLK cycles), with SYNC_STAGES=2:
  - RISING and FALLING each pulse exactly 1 cycle, 3 cycles after each transition.
  - No strobe during the first 3 cycles after reset release, even with MCCLK held high.
  - PERIOD = 17 and PERIOD_VALID = 1 after the second rising strobe.
- Read, RW=1, DTACK_n low and held:
  - ACK_LATCH[0] rises exactly 2+15+1 = 18 cycles after the input falls.
  - ANY_LATCH matches it.
  - Both fall 3 cycles after DTACK_n rises.
- Write, RW=0, then RW toggled to 1 mid-count:
  - Latch at 2+2+1 = 5 cycles; the RW change is ignored.
- Glitch: DTACK_n low for 10 cycles, high for 1 synced cycle, then low:
  - Count restarts; latch 18 cycles after the second fall.
- VPA and BERR asserted in the same cycle as DTACK:
  - All three latches rise in the same cycle.
  - Pulsing nRESET low mid-count clears all outputs next edge; the count restarts on release.
- MCCLK stopped for more than 255 cycles:
  - PERIOD_VALID falls when phase_cnt reaches 255.
  - It returns after two rising strobes once MCCLK restarts.
